garo_sampler_ctrl: RTL and testbench

//  Controller for the GaRO ring-oscillator entropy source. Gates the oscillator

---
 rtl/garo_sampler_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_garo_sampler_ctrl.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/garo_sampler_ctrl.sv
// GaRO entropy source controller: oscillator gating, warm-up, sample decimation into
// WORD_W-bit words with a valid/ready hand-off, and a repetition-count health test.
//
//  state     | meaning
//  ----------+-------------------------------------------------------------
//  S_IDLE    | oscillator off, waiting for enable
//  S_WARMUP  | oscillator running, samples discarded for WARMUP_CYCLES
//  S_COLLECT | decimating entropy_in into the shift register, RCT active
//  S_PRESENT | completed word offered on data/data_valid until data_ready
//  S_FAULT   | RCT tripped, oscillator off, waiting for clear_fault
module garo_sampler_ctrl #(
   parameter int WORD_W        = 32,
   parameter int WARMUP_CYCLES = 256,
   parameter int SAMPLE_DIV    = 4,
   parameter int RCT_CUTOFF    = 32
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              enable,
   input  logic              entropy_in,
   output logic              osc_en,
   output logic [WORD_W-1:0] data,
   output logic              data_valid,
   input  logic              data_ready,
   output logic              health_fail,
   input  logic              clear_fault,
   output logic              busy
);

   localparam int WCNT_W = $clog2(WARMUP_CYCLES + 1);
   localparam int DIV_W  = $clog2(SAMPLE_DIV + 1);
   localparam int BCNT_W = $clog2(WORD_W + 1);
   localparam int RUN_W  = $clog2(RCT_CUTOFF + 1);

   localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(WARMUP_CYCLES - 1);
   localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(SAMPLE_DIV - 1);
   localparam logic [BCNT_W-1:0] BCNT_LAST = BCNT_W'(WORD_W - 1);
   localparam logic [RUN_W-1:0]  RUN_CUT   = RUN_W'(RCT_CUTOFF);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_WARMUP  = 3'd1,
      S_COLLECT = 3'd2,
      S_PRESENT = 3'd3,
      S_FAULT   = 3'd4
   } state_t;

   state_t state;
   state_t state_nxt;

   logic [WCNT_W-1:0] wcnt;
   logic [DIV_W-1:0]  div_cnt;
   logic [BCNT_W-1:0] bcnt;
   logic [WORD_W-1:0] shift_q;
   logic [WORD_W-1:0] shift_nxt;
   logic [RUN_W-1:0]  run;
   logic [RUN_W-1:0]  run_nxt;
   logic              last_q;

   logic sample_tick;
   logic word_done;
   logic rct_trip;

   logic osc_en_nxt;
   logic data_valid_nxt;
   logic health_fail_nxt;
   logic busy_nxt;

   assign sample_tick = (state == S_COLLECT) && (div_cnt == DIV_LAST);
   assign word_done   = sample_tick && (bcnt == BCNT_LAST);
   assign shift_nxt   = {shift_q[WORD_W-2:0], entropy_in};

   // Run length saturates at the cutoff so it can never wrap back below it.
   always_comb begin
      run_nxt = RUN_W'(1);
      if (entropy_in == last_q) begin
         run_nxt = (run == RUN_CUT) ? run : run + RUN_W'(1);
      end
   end

   assign rct_trip = sample_tick && (run_nxt == RUN_CUT);

   // State register and registered outputs
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state       <= S_IDLE;
         osc_en      <= 1'b0;
         data_valid  <= 1'b0;
         health_fail <= 1'b0;
         busy        <= 1'b0;
      end else begin
         state       <= state_nxt;
         osc_en      <= osc_en_nxt;
         data_valid  <= data_valid_nxt;
         health_fail <= health_fail_nxt;
         busy        <= busy_nxt;
      end
   end

   // Next-state logic; an RCT trip outranks both abort and word completion.
   always_comb begin
      state_nxt = state;
      unique case (state)
         S_IDLE: begin
            if (enable) state_nxt = S_WARMUP;
         end
         S_WARMUP: begin
            if (!enable)                 state_nxt = S_IDLE;
            else if (wcnt == WCNT_LAST)  state_nxt = S_COLLECT;
         end
         S_COLLECT: begin
            if (rct_trip)        state_nxt = S_FAULT;
            else if (!enable)    state_nxt = S_IDLE;
            else if (word_done)  state_nxt = S_PRESENT;
         end
         S_PRESENT: begin
            if (data_ready) state_nxt = enable ? S_COLLECT : S_IDLE;
         end
         S_FAULT: begin
            if (clear_fault) state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // Output logic: every flag is a pure function of the state being entered.
   always_comb begin
      osc_en_nxt      = 1'b0;
      data_valid_nxt  = 1'b0;
      health_fail_nxt = 1'b0;
      busy_nxt        = (state_nxt != S_IDLE);
      unique case (state_nxt)
         S_WARMUP, S_COLLECT: osc_en_nxt = 1'b1;
         S_PRESENT: begin
            osc_en_nxt     = 1'b1;
            data_valid_nxt = 1'b1;
         end
         S_FAULT:   health_fail_nxt = 1'b1;
         default: ;
      endcase
   end

   // Counters, shift register, RCT state and the presented word
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wcnt    <= '0;
         div_cnt <= '0;
         bcnt    <= '0;
         shift_q <= '0;
         run     <= '0;
         last_q  <= 1'b0;
         data    <= '0;
      end else begin
         if (state == S_IDLE && enable) begin
            wcnt   <= '0;
            run    <= '0;
            last_q <= 1'b0;
         end else if (state == S_WARMUP) begin
            wcnt <= wcnt + WCNT_W'(1);
         end

         // Divider and bit count only advance while staying in COLLECT, so any
         // exit (abort, fault, word complete) leaves them at zero for re-entry.
         if (state == S_COLLECT && state_nxt == S_COLLECT) begin
            div_cnt <= sample_tick ? '0 : div_cnt + DIV_W'(1);
            if (sample_tick) bcnt <= bcnt + BCNT_W'(1);
         end else begin
            div_cnt <= '0;
            bcnt    <= '0;
         end

         if (sample_tick) begin
            shift_q <= shift_nxt;
            run     <= run_nxt;
            last_q  <= entropy_in;
         end

         if (word_done && !rct_trip) begin
            data <= shift_nxt;
         end
      end
   end

endmodule

// File: tb/tb_garo_sampler_ctrl.sv
// Directed bench for garo_sampler_ctrl with WORD_W=8, WARMUP_CYCLES=4, SAMPLE_DIV=2,
// RCT_CUTOFF=6. Inputs change 1 time unit after the rising edge; outputs are checked there.
module tb_garo_sampler_ctrl;

   logic       clk;
   logic       reset_n;
   logic       enable;
   logic       entropy_in;
   logic       osc_en;
   logic [7:0] data;
   logic       data_valid;
   logic       data_ready;
   logic       health_fail;
   logic       clear_fault;
   logic       busy;

   int n_tests = 0;
   int n_fail  = 0;

   garo_sampler_ctrl #(
      .WORD_W(8), .WARMUP_CYCLES(4), .SAMPLE_DIV(2), .RCT_CUTOFF(6)
   ) dut (
      .clk(clk), .reset_n(reset_n), .enable(enable), .entropy_in(entropy_in),
      .osc_en(osc_en), .data(data), .data_valid(data_valid), .data_ready(data_ready),
      .health_fail(health_fail), .clear_fault(clear_fault), .busy(busy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_idle_outputs(input string tag, input logic [7:0] exp_data);
      check({tag, " osc_en"}, 32'(osc_en), 32'd0);
      check({tag, " data_valid"}, 32'(data_valid), 32'd0);
      check({tag, " health_fail"}, 32'(health_fail), 32'd0);
      check({tag, " busy"}, 32'(busy), 32'd0);
      check({tag, " data"}, 32'(data), 32'(exp_data));
   endtask

   // Called in the first COLLECT cycle; each bit is held for both divider phases.
   // Returns in the cycle where the word must be presented.
   task automatic collect_word(input string tag, input logic [7:0] w);
      for (int i = 0; i < 8; i++) begin
         entropy_in = w[7-i];
         step();
         if (i == 7) check({tag, " valid early"}, 32'(data_valid), 32'd0);
         step();
      end
      check({tag, " valid"}, 32'(data_valid), 32'd1);
      check({tag, " data"}, 32'(data), 32'(w));
      check({tag, " health_fail"}, 32'(health_fail), 32'd0);
   endtask

   initial begin
      reset_n     = 1'b0;
      enable      = 1'b0;
      entropy_in  = 1'b0;
      data_ready  = 1'b0;
      clear_fault = 1'b0;
      #1;
      check_idle_outputs("reset", 8'h00);
      step();
      step();
      reset_n = 1'b1;

      // Nominal word
      enable = 1'b1;
      step();
      check("nom osc_en c1", 32'(osc_en), 32'd1);
      check("nom busy c1", 32'(busy), 32'd1);
      repeat (3) step();
      check("nom valid c4", 32'(data_valid), 32'd0);
      step();
      collect_word("nom", 8'hB2);

      // Backpressure, then back-to-back word without warm-up
      repeat (10) step();
      check("bp valid held", 32'(data_valid), 32'd1);
      check("bp data held", 32'(data), 32'hB2);
      data_ready = 1'b1;
      step();
      data_ready = 1'b0;
      check("bp valid drop", 32'(data_valid), 32'd0);
      check("bp osc_en on", 32'(osc_en), 32'd1);
      collect_word("bp word2", 8'h5A);
      data_ready = 1'b1;
      step();
      data_ready = 1'b0;
      check("bp2 valid drop", 32'(data_valid), 32'd0);
      check("bp2 busy", 32'(busy), 32'd1);
      enable = 1'b0;
      step();
      check("bp2 abort osc_en", 32'(osc_en), 32'd0);
      check("bp2 abort busy", 32'(busy), 32'd0);

      // RCT fault on a stuck-at-1 source
      entropy_in = 1'b1;
      enable     = 1'b1;
      repeat (16) step();
      check("rct pre health", 32'(health_fail), 32'd0);
      check("rct pre osc_en", 32'(osc_en), 32'd1);
      step();
      check("rct health", 32'(health_fail), 32'd1);
      check("rct osc_en", 32'(osc_en), 32'd0);
      check("rct valid", 32'(data_valid), 32'd0);
      check("rct busy", 32'(busy), 32'd1);
      data_ready = 1'b1;
      repeat (3) step();
      check("rct sticky", 32'(health_fail), 32'd1);
      check("rct sticky osc", 32'(osc_en), 32'd0);
      data_ready  = 1'b0;
      enable      = 1'b0;
      clear_fault = 1'b1;
      step();
      clear_fault = 1'b0;
      check("rct cleared", 32'(health_fail), 32'd0);
      check("rct cleared busy", 32'(busy), 32'd0);

      // Abort after three samples, then a full warm-up on re-enable
      entropy_in = 1'b0;
      enable     = 1'b1;
      repeat (11) step();
      check("abort pre busy", 32'(busy), 32'd1);
      enable = 1'b0;
      step();
      check("abort osc_en", 32'(osc_en), 32'd0);
      check("abort valid", 32'(data_valid), 32'd0);
      check("abort busy", 32'(busy), 32'd0);
      enable = 1'b1;
      step();
      check("reen osc_en", 32'(osc_en), 32'd1);
      repeat (4) step();
      collect_word("reen", 8'hB2);

      // enable dropped while presenting
      enable = 1'b0;
      repeat (2) step();
      check("pres valid held", 32'(data_valid), 32'd1);
      check("pres osc_en held", 32'(osc_en), 32'd1);
      data_ready = 1'b1;
      step();
      data_ready = 1'b0;
      check_idle_outputs("pres done", 8'hB2);

      // Asynchronous reset while in COLLECT
      enable = 1'b1;
      repeat (7) step();
      check("arst pre osc_en", 32'(osc_en), 32'd1);
      #2 reset_n = 1'b0;
      #1;
      check_idle_outputs("arst collect", 8'h00);
      step();
      reset_n = 1'b1;
      step();
      check("arst restart osc_en", 32'(osc_en), 32'd1);
      check("arst restart busy", 32'(busy), 32'd1);
      repeat (4) step();
      collect_word("arst word", 8'h96);
      data_ready = 1'b1;
      enable     = 1'b0;
      step();
      data_ready = 1'b0;

      // Asynchronous reset while in FAULT
      entropy_in = 1'b1;
      enable     = 1'b1;
      repeat (17) step();
      check("arst2 fault", 32'(health_fail), 32'd1);
      #2 reset_n = 1'b0;
      #1;
      check_idle_outputs("arst fault", 8'h00);
      step();
      reset_n = 1'b1;
      step();
      check("arst2 restart osc_en", 32'(osc_en), 32'd1);
      check("arst2 restart health", 32'(health_fail), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
